// File: rtl/stream_xbar_tag_tracker_pkg.sv
// stream_xbar_tag_tracker_pkg: shared widths, tag type and perf-counter convention
package stream_xbar_tag_tracker_pkg;
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
  localparam int DEF_IN_WIDTH = log2up(4);
  typedef logic [DEF_IN_WIDTH-1:0] tag_t;
  function automatic logic [63:0] perf_ctr_next(input logic [63:0] ctr, input logic inc);
    return ctr + {63'd0, inc};
  endfunction
endpackage

// File: rtl/stream_xbar_tag_fifo.sv
// stream_xbar_tag_fifo: register-file FIFO holding source tags of outstanding requests
module stream_xbar_tag_fifo
  import stream_xbar_tag_tracker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 2,
  parameter int CNTW = cnt_width(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [W-1:0]    din,
  input  logic            pop,
  output logic [W-1:0]    head,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  // next-state for storage, pointers (natural power-of-two wrap) and occupancy
  always_comb begin
    mem_d = mem_q;
    mem_d[wr_q] = push ? din : mem_q[wr_q];
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);
  end
  // pointers and count reset; stored tags are meaningless while count is zero
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // tag storage
  always_ff @(posedge clk) mem_q <= mem_d;
  assign head = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == CNTW'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/stream_xbar_tag_tracker.sv
// stream_xbar_tag_tracker: tags in-order target responses with the crossbar source index
module stream_xbar_tag_tracker
  import stream_xbar_tag_tracker_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW = 32,
  parameter int RSP_DATAW = 32,
  parameter int DEPTH = 4,
  parameter int PERF_CTR_BITS = 16,
  parameter int IN_WIDTH = log2up(NUM_INPUTS),
  parameter int CNTW = cnt_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid_in,
  input  logic [DATAW-1:0]         req_data_in,
  input  logic [IN_WIDTH-1:0]      req_sel_in,
  output logic                     req_ready_in,
  output logic                     req_valid_out,
  output logic [DATAW-1:0]         req_data_out,
  input  logic                     req_ready_out,
  input  logic                     rsp_valid_in,
  input  logic [RSP_DATAW-1:0]     rsp_data_in,
  output logic                     rsp_ready_in,
  output logic                     rsp_valid_out,
  output logic [RSP_DATAW-1:0]     rsp_data_out,
  output logic [IN_WIDTH-1:0]      rsp_sel_out,
  input  logic                     rsp_ready_out,
  output logic [CNTW-1:0]          pending,
  output logic [PERF_CTR_BITS-1:0] stalls,
  output logic                     orphan_err
);
  logic full, empty, req_fire, rsp_fire;
  logic req_fire_prev_q, req_fire_prev_d, orphan_q, orphan_d;
  logic [PERF_CTR_BITS-1:0] stalls_q, stalls_d;
  // no bypass: full blocks requests and empty blocks responses regardless of the other side
  assign req_valid_out = req_valid_in & ~full;
  assign req_ready_in = req_ready_out & ~full;
  assign req_data_out = req_data_in;
  assign req_fire = req_valid_in & req_ready_in;
  assign rsp_valid_out = rsp_valid_in & ~empty;
  assign rsp_ready_in = rsp_ready_out & ~empty;
  assign rsp_data_out = rsp_data_in;
  assign rsp_fire = rsp_valid_out & rsp_ready_out;
  stream_xbar_tag_fifo #(.DEPTH(DEPTH), .W(IN_WIDTH), .CNTW(CNTW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(req_fire),
    .din(req_sel_in),
    .pop(rsp_fire),
    .head(rsp_sel_out),
    .count(pending),
    .full(full),
    .empty(empty)
  );
  // a response on an empty tracker is only legitimate if a request fired just before it
  always_comb begin
    req_fire_prev_d = req_fire;
    orphan_d = orphan_q | (rsp_valid_in & empty & ~req_fire_prev_q);
    stalls_d = PERF_CTR_BITS'(perf_ctr_next(64'(stalls_q), req_valid_in & full));
  end
  // status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      req_fire_prev_q <= 1'b0;
      orphan_q <= 1'b0;
      stalls_q <= '0;
    end else begin
      req_fire_prev_q <= req_fire_prev_d;
      orphan_q <= orphan_d;
      stalls_q <= stalls_d;
    end
  end
  assign stalls = stalls_q;
  assign orphan_err = orphan_q;
endmodule

// File: tb/tb_stream_xbar_tag_tracker.sv
// tb_stream_xbar_tag_tracker: directed scoreboard bench for the tag tracker
module tb_stream_xbar_tag_tracker;
  logic clk = 1'b0;
  logic reset;
  logic req_valid_in, req_ready_in, req_valid_out, req_ready_out;
  logic [31:0] req_data_in, req_data_out;
  logic [1:0] req_sel_in, rsp_sel_out;
  logic rsp_valid_in, rsp_ready_in, rsp_valid_out, rsp_ready_out;
  logic [31:0] rsp_data_in, rsp_data_out;
  logic [2:0] pending;
  logic [15:0] stalls;
  logic orphan_err;
  int errors = 0;
  int checks = 0;
  int mpend = 0;
  logic [15:0] mst = '0;
  logic morph = 1'b0;
  logic mprev = 1'b0;
  logic [1:0] sb [$];
  logic [1:0] held_sel;
  logic [31:0] held_data;

  always #5 clk = ~clk;

  stream_xbar_tag_tracker dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_sel_in(req_sel_in),
    .req_ready_in(req_ready_in), .req_valid_out(req_valid_out), .req_data_out(req_data_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_sel_out(rsp_sel_out),
    .rsp_ready_out(rsp_ready_out),
    .pending(pending), .stalls(stalls), .orphan_err(orphan_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rv, input logic [1:0] sel, input logic sv,
                      input logic rro = 1'b1, input logic sro = 1'b1, input logic keep_data = 1'b0);
    logic efull, eempty, rf, pf;
    req_valid_in = rv;
    req_sel_in = sel;
    req_data_in = $urandom;
    req_ready_out = rro;
    rsp_valid_in = sv;
    if (!keep_data) rsp_data_in = $urandom;
    rsp_ready_out = sro;
    #2;
    efull = mpend == 4;
    eempty = mpend == 0;
    rf = rv & rro & ~efull;
    pf = sv & sro & ~eempty;
    chk("pending", 32'(pending), 32'(mpend));
    chk("stalls", 32'(stalls), 32'(mst));
    chk("orphan_err", 32'(orphan_err), 32'(morph));
    chk("req_valid_out", 32'(req_valid_out), 32'(rv & ~efull));
    chk("req_ready_in", 32'(req_ready_in), 32'(rro & ~efull));
    chk("req_data_out", req_data_out, req_data_in);
    chk("rsp_valid_out", 32'(rsp_valid_out), 32'(sv & ~eempty));
    chk("rsp_ready_in", 32'(rsp_ready_in), 32'(sro & ~eempty));
    chk("rsp_data_out", rsp_data_out, rsp_data_in);
    if (sv && !eempty) chk("rsp_sel_out", 32'(rsp_sel_out), 32'(sb[0]));
    @(posedge clk);
    #1;
    if (sv && eempty && !mprev) morph = 1'b1;
    if (rv && efull) mst = mst + 16'd1;
    mprev = rf;
    if (pf) void'(sb.pop_front());
    if (rf) sb.push_back(sel);
    mpend = mpend + int'(rf) - int'(pf);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid_in = 1'b0;
    rsp_valid_in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mpend = 0;
    mst = '0;
    morph = 1'b0;
    mprev = 1'b0;
    sb.delete();
  endtask

  initial begin
    reset = 1'b1;
    req_valid_in = 1'b0;
    req_sel_in = '0;
    req_data_in = '0;
    req_ready_out = 1'b1;
    rsp_valid_in = 1'b0;
    rsp_data_in = '0;
    rsp_ready_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_stalls", 32'(stalls), 32'd0);
    chk("reset_orphan", 32'(orphan_err), 32'd0);
    step(0, 0, 0);
    // single transaction
    step(1, 2, 0);
    chk("single_pending_1", 32'(pending), 32'd1);
    step(0, 0, 0);
    step(0, 0, 0);
    #1 chk("single_sel", 32'(rsp_sel_out), 32'd2);
    step(0, 0, 1);
    chk("single_pending_0", 32'(pending), 32'd0);
    chk("single_stalls", 32'(stalls), 32'd0);
    // fill to depth, stall three cycles, drain in order
    for (int i = 0; i < 4; i++) step(1, 2'(i), 0);
    chk("fill_pending", 32'(pending), 32'd4);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    chk("fill_stalls", 32'(stalls), 32'd3);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1'b1, 1'b1, 1'b0);
    end
    chk("drain_pending", 32'(pending), 32'd0);
    // simultaneous push/pop at 2 and at full
    step(1, 3, 0);
    step(1, 1, 0);
    step(1, 2, 1);
    chk("simul_pending", 32'(pending), 32'd2);
    step(1, 0, 0);
    step(1, 3, 0);
    chk("simul_full", 32'(pending), 32'd4);
    step(1, 2, 1);
    chk("full_blocked", 32'(pending), 32'd3);
    step(1, 2, 0);
    chk("full_next_accept", 32'(pending), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    // wrap-around, each response two cycles after its request
    for (int t = 0; t < 12; t++) step(t < 10, 2'(t % 4), t >= 2);
    chk("wrap_pending", 32'(pending), 32'd0);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);
    // response back-pressure
    step(1, 3, 0);
    rsp_data_in = 32'hdead_beef;
    held_sel = 2'd3;
    held_data = 32'hdead_beef;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1'b1, 1'b0, 1'b1);
      chk("bp_sel_stable", 32'(rsp_sel_out), 32'(held_sel));
      chk("bp_data_stable", rsp_data_out, held_data);
      chk("bp_pending", 32'(pending), 32'd1);
    end
    step(0, 0, 1);
    chk("bp_release", 32'(pending), 32'd0);
    // orphan response
    step(0, 0, 0);
    step(0, 0, 1);
    chk("orphan_set", 32'(orphan_err), 32'd1);
    step(0, 0, 0);
    chk("orphan_sticky", 32'(orphan_err), 32'd1);
    // reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 2'(i + 1), 0);
    chk("pre_reset_pending", 32'(pending), 32'd3);
    do_reset();
    chk("mid_reset_pending", 32'(pending), 32'd0);
    chk("mid_reset_orphan", 32'(orphan_err), 32'd0);
    chk("mid_reset_stalls", 32'(stalls), 32'd0);
    step(1, 1, 0);
    step(0, 0, 1);
    chk("post_reset_pending", 32'(pending), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
